spi_accel_responder: RTL and testbench

- SPI responder (target) that emulates the 3-axis accelerometer's register interface, for closed-loop simulation and FPGA self-test of the existing SPI initiator (spi_control).
- Receives SPI mode 3 (CPOL=1, CPHA=1) 4-wire transactions on the system clock domain using oversampled, synchronised pins.
- Serves a 64-byte register file; axis data registers come from parallel sample inputs.
- Sits between a stimulus source (pattern generator or testbench) and the GSENSOR pins of the design under test.

---
 rtl/spi_resp_pkg.sv | 28 ++
 rtl/sync_edge_detect.sv | 32 +++
 rtl/spi_accel_responder.sv | 181 ++++++++++++++++++
 tb/tb_spi_accel_responder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI accelerometer responder.
// Holds the FSM encoding, fixed register addresses and command-byte field positions.
package spi_resp_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StRead,
        StWrite
    } state_e;

    localparam logic [5:0] ADDR_DEVID  = 6'h00;
    localparam logic [5:0] ADDR_DATAX0 = 6'h32;
    localparam logic [5:0] ADDR_DATAX1 = 6'h33;
    localparam logic [5:0] ADDR_DATAY0 = 6'h34;
    localparam logic [5:0] ADDR_DATAY1 = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0 = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1 = 6'h37;

    localparam int unsigned RW_BIT = 7;
    localparam int unsigned MB_BIT = 6;

    // DEVID and the axis data bytes are not backed by storage.
    function automatic logic is_read_only(input logic [5:0] addr);
        return (addr == ADDR_DEVID) || ((addr >= ADDR_DATAX0) && (addr <= ADDR_DATAZ1));
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop pin synchroniser with registered rise/fall pulses.
// Pulses appear SYNC_STAGES+1 cycles after the pin edge.
module sync_edge_detect #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // Top bit is the previous synchronised level, used only for edge detection.
    logic [SYNC_STAGES:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {(SYNC_STAGES + 1){RESET_VAL}};
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-1:0], d_i};
            rise_o <= sync_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES];
            fall_o <= ~sync_q[SYNC_STAGES-1] & sync_q[SYNC_STAGES];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-3 target emulating an accelerometer register file on the system clock.
// Axis bytes come from a snapshot of the shadow samples taken at chip-select fall.
module spi_accel_responder
    import spi_resp_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  DEVID_VAL   = 8'hE5,
    parameter int unsigned ADDR_W      = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_csn,
    input  logic              spi_sclk,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              spi_sdo_oe,
    input  logic [15:0]       sample_x,
    input  logic [15:0]       sample_y,
    input  logic [15:0]       sample_z,
    input  logic              sample_valid,
    output logic              reg_wr_strobe,
    output logic [ADDR_W-1:0] reg_wr_addr,
    output logic [7:0]        reg_wr_data,
    output logic              busy
);

    localparam int unsigned NumRegs = 2 ** ADDR_W;

    logic sclk_rise, sclk_fall, csn_rise, csn_fall, sdi_s;
    logic unused_sclk_level, unused_csn_level, unused_sdi_rise, unused_sdi_fall;

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (spi_sclk),
        .level_o(unused_sclk_level),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_csn (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (spi_csn),
        .level_o(unused_csn_level),
        .rise_o (csn_rise),
        .fall_o (csn_fall)
    );

    sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .d_i    (spi_sdi),
        .level_o(sdi_s),
        .rise_o (unused_sdi_rise),
        .fall_o (unused_sdi_fall)
    );

    state_e            state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              mb_q;
    logic [47:0]       shadow_q;
    logic [47:0]       snap_q;
    logic [7:0]        regs_q [NumRegs];

    logic [7:0]        rx_byte;
    logic [ADDR_W-1:0] addr_inc;

    assign rx_byte  = {shift_q[6:0], sdi_s};
    assign addr_inc = addr_q + 1'b1;
    assign busy     = (state_q != StIdle);

    // Snapshot layout is {x, y, z}; each axis is returned little-endian.
    function automatic logic [7:0] rd_byte(input logic [ADDR_W-1:0] a);
        case (a)
            ADDR_DEVID:  return DEVID_VAL;
            ADDR_DATAX0: return snap_q[39:32];
            ADDR_DATAX1: return snap_q[47:40];
            ADDR_DATAY0: return snap_q[23:16];
            ADDR_DATAY1: return snap_q[31:24];
            ADDR_DATAZ0: return snap_q[7:0];
            ADDR_DATAZ1: return snap_q[15:8];
            default:     return regs_q[a];
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tx_q          <= '0;
            addr_q        <= '0;
            mb_q          <= 1'b0;
            shadow_q      <= '0;
            snap_q        <= '0;
            spi_sdo       <= 1'b0;
            spi_sdo_oe    <= 1'b0;
            reg_wr_strobe <= 1'b0;
            reg_wr_addr   <= '0;
            reg_wr_data   <= '0;
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            reg_wr_strobe <= 1'b0;
            if (sample_valid) begin
                shadow_q <= {sample_x, sample_y, sample_z};
            end

            if (csn_rise) begin
                state_q    <= StIdle;
                spi_sdo_oe <= 1'b0;
                spi_sdo    <= 1'b0;
            end else if (csn_fall) begin
                // Also restarts a transaction that saw a CSN glitch.
                state_q    <= StCmd;
                bit_cnt_q  <= '0;
                spi_sdo_oe <= 1'b0;
                snap_q     <= sample_valid ? {sample_x, sample_y, sample_z} : shadow_q;
            end else begin
                case (state_q)
                    StCmd: begin
                        if (sclk_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                mb_q   <= rx_byte[MB_BIT];
                                addr_q <= rx_byte[ADDR_W-1:0];
                                if (rx_byte[RW_BIT]) begin
                                    state_q    <= StRead;
                                    tx_q       <= rd_byte(rx_byte[ADDR_W-1:0]);
                                    spi_sdo_oe <= 1'b1;
                                end else begin
                                    state_q <= StWrite;
                                end
                            end
                        end
                    end
                    StRead: begin
                        if (sclk_fall) begin
                            spi_sdo   <= tx_q[7];
                            tx_q      <= {tx_q[6:0], 1'b0};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (mb_q) begin
                                    addr_q <= addr_inc;
                                    tx_q   <= rd_byte(addr_inc);
                                end else begin
                                    tx_q <= rd_byte(addr_q);
                                end
                            end
                        end
                    end
                    StWrite: begin
                        if (sclk_rise) begin
                            shift_q   <= rx_byte;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                if (!is_read_only(addr_q)) begin
                                    regs_q[addr_q] <= rx_byte;
                                    reg_wr_strobe  <= 1'b1;
                                    reg_wr_addr    <= addr_q;
                                    reg_wr_data    <= rx_byte;
                                end
                                if (mb_q) begin
                                    addr_q <= addr_inc;
                                end
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_accel_responder.sv
// Self-checking bench: table of single-byte transactions plus burst, wrap,
// abort and reset sequences driven as an SPI mode-3 initiator.
module tb_spi_accel_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        spi_csn = 1'b1;
    logic        spi_sclk = 1'b1;
    logic        spi_sdi = 1'b0;
    logic        spi_sdo, spi_sdo_oe;
    logic [15:0] sample_x = '0, sample_y = '0, sample_z = '0;
    logic        sample_valid = 1'b0;
    logic        reg_wr_strobe;
    logic [5:0]  reg_wr_addr;
    logic [7:0]  reg_wr_data;
    logic        busy;

    spi_accel_responder dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .spi_csn      (spi_csn),
        .spi_sclk     (spi_sclk),
        .spi_sdi      (spi_sdi),
        .spi_sdo      (spi_sdo),
        .spi_sdo_oe   (spi_sdo_oe),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .sample_z     (sample_z),
        .sample_valid (sample_valid),
        .reg_wr_strobe(reg_wr_strobe),
        .reg_wr_addr  (reg_wr_addr),
        .reg_wr_data  (reg_wr_data),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    int         st_total = 0;
    logic [5:0] st_addr [$];
    logic [7:0] st_data [$];

    always @(negedge clk) begin
        if (reg_wr_strobe) begin
            st_addr.push_back(reg_wr_addr);
            st_data.push_back(reg_wr_data);
            st_total++;
        end
    end

    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] exp_rd;
        int         exp_strobes;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic half();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            spi_sclk = 1'b0;
            spi_sdi  = tx[i];
            half();
            spi_sclk = 1'b1;
            rx[i]    = spi_sdo;
            half();
        end
    endtask

    task automatic run_txn(input int nbytes);
        spi_csn = 1'b0;
        half();
        for (int b = 0; b < nbytes; b++) begin
            xfer_byte(tx_buf[b], rx_buf[b]);
        end
        spi_csn = 1'b1;
        half();
        half();
    endtask

    task automatic read1(input logic [5:0] a, output logic [7:0] d);
        tx_buf[0] = {2'b10, a};
        tx_buf[1] = 8'h00;
        run_txn(2);
        d = rx_buf[1];
    endtask

    task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
        sample_x     = x;
        sample_y     = y;
        sample_z     = z;
        sample_valid = 1'b1;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] dummy;
        int base;
        logic [7:0] exp_burst [6];

        vecs[0] = '{8'h80, 8'h00, 8'hE5, 0};
        vecs[1] = '{8'h2D, 8'h08, 8'h00, 1};
        vecs[2] = '{8'hAD, 8'h00, 8'h08, 0};
        vecs[3] = '{8'h00, 8'h55, 8'h00, 0};
        vecs[4] = '{8'h80, 8'h00, 8'hE5, 0};
        vecs[5] = '{8'h20, 8'h5A, 8'h00, 1};
        vecs[6] = '{8'hA0, 8'h00, 8'h5A, 0};
        vecs[7] = '{8'h33, 8'h77, 8'h00, 0};
        vecs[8] = '{8'hB3, 8'h00, 8'h00, 0};

        repeat (3) @(posedge clk);
        #1;
        check("reset_sdo", spi_sdo, 1'b0);
        check("reset_oe", spi_sdo_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_strobe", reg_wr_strobe, 1'b0);
        reset_n = 1'b1;
        half();

        // Read DEVID with output-enable timing checks.
        spi_csn = 1'b0;
        half();
        check("cmd_oe_low", spi_sdo_oe, 1'b0);
        check("cmd_busy", busy, 1'b1);
        xfer_byte(8'h80, dummy);
        check("data_oe_high", spi_sdo_oe, 1'b1);
        xfer_byte(8'h00, rd);
        check("devid_read", rd, 8'hE5);
        check("oe_before_csn", spi_sdo_oe, 1'b1);
        spi_csn = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("oe_after_csn", spi_sdo_oe, 1'b0);
        check("busy_after_csn", busy, 1'b0);
        half();

        for (int v = 0; v < 9; v++) begin
            base = st_total;
            tx_buf[0] = vecs[v].cmd;
            tx_buf[1] = vecs[v].data;
            run_txn(2);
            check($sformatf("vec%0d_strobes", v), st_total - base, vecs[v].exp_strobes);
            if (vecs[v].cmd[7]) begin
                check($sformatf("vec%0d_rd", v), rx_buf[1], vecs[v].exp_rd);
            end else if (vecs[v].exp_strobes == 1 && st_total > base) begin
                check($sformatf("vec%0d_addr", v), st_addr[base], vecs[v].cmd[5:0]);
                check($sformatf("vec%0d_data", v), st_data[base], vecs[v].data);
            end
        end

        // Burst read of axis data; mid-burst sample must not disturb the snapshot.
        pulse_sample(16'h1234, 16'hFF80, 16'h0100);
        exp_burst = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
        spi_csn = 1'b0;
        half();
        xfer_byte(8'hF2, dummy);
        for (int b = 0; b < 6; b++) begin
            xfer_byte(8'h00, rd);
            check($sformatf("burst_b%0d", b), rd, exp_burst[b]);
            if (b == 1) pulse_sample(16'hABCD, 16'h0000, 16'h0000);
        end
        spi_csn = 1'b1;
        half();
        half();
        read1(6'h33, rd);
        check("new_snapshot_x1", rd, 8'hAB);

        // MB=0: repeated reads and rewrites of one address.
        tx_buf[0] = 8'h80; tx_buf[1] = 8'h00; tx_buf[2] = 8'h00;
        run_txn(3);
        check("mb0_read_b0", rx_buf[1], 8'hE5);
        check("mb0_read_b1", rx_buf[2], 8'hE5);
        base = st_total;
        tx_buf[0] = 8'h10; tx_buf[1] = 8'h01; tx_buf[2] = 8'h02;
        run_txn(3);
        check("mb0_write_strobes", st_total - base, 2);
        read1(6'h10, rd);
        check("mb0_write_last", rd, 8'h02);

        // MB write wrapping 0x3F -> 0x00 (ignored) -> 0x01.
        base = st_total;
        tx_buf[0] = 8'h7F; tx_buf[1] = 8'hAA; tx_buf[2] = 8'hBB; tx_buf[3] = 8'hCC;
        run_txn(4);
        check("wrap_strobes", st_total - base, 2);
        if (st_total - base == 2) begin
            check("wrap_addr0", st_addr[base], 6'h3F);
            check("wrap_data0", st_data[base], 8'hAA);
            check("wrap_addr1", st_addr[base+1], 6'h01);
            check("wrap_data1", st_data[base+1], 8'hCC);
        end
        read1(6'h3F, rd);
        check("wrap_rd_3f", rd, 8'hAA);
        read1(6'h00, rd);
        check("wrap_rd_devid", rd, 8'hE5);

        // Abort a write to 0x20 after 5 data bits.
        base = st_total;
        spi_csn = 1'b0;
        half();
        xfer_byte(8'h20, dummy);
        for (int i = 0; i < 5; i++) begin
            spi_sclk = 1'b0; spi_sdi = 1'b1; half();
            spi_sclk = 1'b1; half();
        end
        spi_csn = 1'b1;
        half();
        half();
        check("abort_no_strobe", st_total - base, 0);
        read1(6'h20, rd);
        check("abort_reg_kept", rd, 8'h5A);

        // Asynchronous reset in the middle of a read data byte.
        spi_csn = 1'b0;
        half();
        xfer_byte(8'h80, dummy);
        for (int i = 0; i < 3; i++) begin
            spi_sclk = 1'b0; half();
            spi_sclk = 1'b1; half();
        end
        check("pre_reset_oe", spi_sdo_oe, 1'b1);
        #3;
        reset_n = 1'b0;
        #1;
        check("rst_oe", spi_sdo_oe, 1'b0);
        check("rst_sdo", spi_sdo, 1'b0);
        check("rst_busy", busy, 1'b0);
        spi_csn  = 1'b1;
        spi_sclk = 1'b1;
        repeat (4) @(posedge clk);
        #3;
        reset_n = 1'b1;
        half();
        read1(6'h00, rd);
        check("post_rst_devid", rd, 8'hE5);
        read1(6'h2D, rd);
        check("post_rst_cleared", rd, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
